f_xor_syndrome: RTL and testbench



---
 rtl/f_xor_syndrome_pkg.sv | 44 ++++
 rtl/f_xor_syndrome_if.sv | 23 ++
 rtl/f_xor_syndrome_xor.sv | 50 +++++
 rtl/f_xor_syndrome.sv | 105 ++++++++++
 tb/tb_f_xor_syndrome.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/f_xor_syndrome_pkg.sv
// Shared types and elaboration helpers for the XOR syndrome engine and its
// per-output XOR trees.
package f_xor_syndrome_pkg;

  // Frame qualifiers carried alongside the tree data
  typedef struct packed {
    logic vld;
    logic sop;
    logic eop;
  } ctrl_t;

  // Leaf fan-in matched to the LUT size of the target family
  function automatic int leaf_size(input int target_chip);
    case (target_chip)
      0:       return 4;
      1:       return 5;
      default: return 6;
    endcase
  endfunction

  // Node count after k reduction levels of an n-input tree
  function automatic int lvl_count(input int n, input int leaf, input int k);
    int c;
    c = n;
    for (int i = 0; i < k; i++) c = (c + leaf - 1) / leaf;
    return c;
  endfunction

  // Levels needed to reduce n inputs to a single bit
  function automatic int num_levels(input int n, input int leaf);
    int l;
    int c;
    l = 0;
    c = n;
    for (int i = 0; i < 32; i++) begin
      if (c > 1) begin
        c = (c + leaf - 1) / leaf;
        l++;
      end
    end
    return l;
  endfunction

endpackage

// File: rtl/f_xor_syndrome_if.sv
// Word-in / syndrome-out bus of the XOR syndrome engine.
interface f_xor_syndrome_if #(
  parameter int WIDTH   = 32,
  parameter int NUM_OUT = 8
);
  logic               din_valid;
  logic               din_sop;
  logic               din_eop;
  logic [WIDTH-1:0]   din;
  logic               dout_valid;
  logic [NUM_OUT-1:0] dout;
  logic               frame_err;

  modport master (
    output din_valid, din_sop, din_eop, din,
    input  dout_valid, dout, frame_err
  );

  modport slave (
    input  din_valid, din_sop, din_eop, din,
    output dout_valid, dout, frame_err
  );
endinterface

// File: rtl/f_xor_syndrome_xor.sv
// f_xor: pipelined XOR reduction of a word to one bit. Levels are built from
// LUT-sized leaves; the first LATENCY levels are registered, and when the tree
// is shallower than LATENCY the extra levels are single-bit pass registers.
// Data registers carry no reset.
module f_xor
  import f_xor_syndrome_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int LATENCY     = 2,
  parameter bit HEAD_INVERT = 1'b0,
  parameter int TARGET_CHIP = 2
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] din_i,
  output logic             dout_o
);
  localparam int LEAF = leaf_size(TARGET_CHIP);
  localparam int NLEV = num_levels(WIDTH, LEAF);
  localparam int NSTG = (NLEV > LATENCY) ? NLEV : LATENCY;

  for (genvar k = 0; k <= NSTG; k++) begin : g_lvl
    localparam int CN = lvl_count(WIDTH, LEAF, k);
    logic [CN-1:0] lvl;

    if (k == 0) begin : g_in
      assign lvl = din_i;
    end else begin : g_red
      localparam int CP = lvl_count(WIDTH, LEAF, k - 1);
      logic [CN*LEAF-1:0] src;
      logic [CN-1:0]      red_d;

      // Zero-pad the previous level and fold it one leaf at a time
      always_comb begin
        src = '0;
        src[CP-1:0] = g_lvl[k-1].lvl;
        for (int g = 0; g < CN; g++) red_d[g] = ^src[g*LEAF +: LEAF];
      end

      if (k <= LATENCY) begin : g_reg
        // Pipeline register after this level
        always_ff @(posedge clk) lvl <= red_d;
      end else begin : g_comb
        assign lvl = red_d;
      end
    end
  end

  assign dout_o = g_lvl[NSTG].lvl[0] ^ HEAD_INVERT;

endmodule

// File: rtl/f_xor_syndrome.sv
// f_xor_syndrome: NUM_OUT masked XOR trees whose results are XOR-accumulated
// over sop/eop-delimited frames. Control qualifiers ride a delay line matched
// to the tree latency; the accumulator adds one register stage.
module f_xor_syndrome
  import f_xor_syndrome_pkg::*;
#(
  parameter int                       WIDTH       = 32,
  parameter int                       NUM_OUT     = 8,
  parameter logic [NUM_OUT*WIDTH-1:0] MASK        = '1,
  parameter int                       LATENCY     = 2,
  parameter bit                       ACCUMULATE  = 1'b1,
  parameter logic [NUM_OUT-1:0]       HEAD_INVERT = '0,
  parameter int                       TARGET_CHIP = 2
) (
  input logic             clk,
  input logic             sclr,
  f_xor_syndrome_if.slave bus
);
  ctrl_t                            ctrl_in, ctrl_dly;
  logic [NUM_OUT-1:0][WIDTH-1:0]    din_m;
  logic [NUM_OUT-1:0]               p;

  // Outside frame mode every word is its own frame
  assign ctrl_in = '{vld: bus.din_valid,
                     sop: bus.din_sop | ~ACCUMULATE,
                     eop: bus.din_eop | ~ACCUMULATE};

  for (genvar j = 0; j < NUM_OUT; j++) begin : g_out
    assign din_m[j] = bus.din & MASK[j*WIDTH +: WIDTH];
    f_xor #(
      .WIDTH      (WIDTH),
      .LATENCY    (LATENCY),
      .HEAD_INVERT(1'b0),
      .TARGET_CHIP(TARGET_CHIP)
    ) u_xor (
      .clk   (clk),
      .din_i (din_m[j]),
      .dout_o(p[j])
    );
  end

  if (LATENCY > 0) begin : g_dly
    ctrl_t [LATENCY:1] vld_pipe_q;
    // Qualifier delay line, aligned with the tree output
    always_ff @(posedge clk) begin
      if (sclr) begin
        vld_pipe_q <= '0;
      end else begin
        vld_pipe_q[1] <= ctrl_in;
        for (int k = 2; k <= LATENCY; k++) vld_pipe_q[k] <= vld_pipe_q[k-1];
      end
    end
    assign ctrl_dly = vld_pipe_q[LATENCY];
  end else begin : g_nodly
    assign ctrl_dly = ctrl_in;
  end

  logic [NUM_OUT-1:0] acc_q, acc_d, dout_q, dout_d, fin;
  logic               in_frame_q, in_frame_d;
  logic               dout_valid_q, dout_valid_d;
  logic               frame_err_q, frame_err_d;
  logic               take;

  // Frame accumulation; a word is taken if it opens a frame or continues one
  always_comb begin
    take         = ctrl_dly.vld & (ctrl_dly.sop | in_frame_q);
    fin          = ctrl_dly.sop ? p : (acc_q ^ p);
    acc_d        = acc_q;
    in_frame_d   = in_frame_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    // Orphan continuation word, or sop that abandons an open frame
    frame_err_d  = ctrl_dly.vld & (ctrl_dly.sop == in_frame_q);
    if (take) begin
      acc_d      = fin;
      in_frame_d = ~ctrl_dly.eop;
      if (ctrl_dly.eop) begin
        dout_d       = fin ^ HEAD_INVERT;
        dout_valid_d = 1'b1;
      end
    end
  end

  // Accumulator and output registers
  always_ff @(posedge clk) begin
    if (sclr) begin
      acc_q        <= '0;
      in_frame_q   <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      in_frame_q   <= in_frame_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.frame_err  = frame_err_q;

endmodule

// File: tb/tb_f_xor_syndrome.sv
// Directed bench for f_xor_syndrome: frame mode (LATENCY=2) on dut0 and
// per-word mode with head inversion (LATENCY=0) on dut1.
module tb_f_xor_syndrome;
  logic clk = 1'b0;
  logic sclr;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  f_xor_syndrome_if #(.WIDTH(8), .NUM_OUT(2)) a ();
  f_xor_syndrome_if #(.WIDTH(8), .NUM_OUT(2)) b ();

  // row1 = 8'h0F, row0 = 8'hFF
  f_xor_syndrome #(
    .WIDTH(8), .NUM_OUT(2), .MASK(16'h0FFF), .LATENCY(2),
    .ACCUMULATE(1'b1), .HEAD_INVERT(2'b00), .TARGET_CHIP(2)
  ) dut0 (.clk(clk), .sclr(sclr), .bus(a.slave));

  f_xor_syndrome #(
    .WIDTH(8), .NUM_OUT(2), .MASK(16'h0FFF), .LATENCY(0),
    .ACCUMULATE(1'b0), .HEAD_INVERT(2'b01), .TARGET_CHIP(2)
  ) dut1 (.clk(clk), .sclr(sclr), .bus(b.slave));

  // Output history per cycle, captured on the falling edge
  logic       hv0 [0:1023];
  logic [1:0] hd0 [0:1023];
  logic       he0 [0:1023];
  logic       hv1 [0:1023];
  logic [1:0] hd1 [0:1023];
  logic       he1 [0:1023];

  always @(negedge clk) begin
    if (cyc < 1024) begin
      hv0[cyc] = a.dout_valid; hd0[cyc] = a.dout; he0[cyc] = a.frame_err;
      hv1[cyc] = b.dout_valid; hd1[cyc] = b.dout; he1[cyc] = b.frame_err;
    end
  end

  task automatic drv0(input logic v, input logic s, input logic e,
                      input logic [7:0] d, output int t);
    @(negedge clk);
    a.din_valid = v; a.din_sop = s; a.din_eop = e; a.din = d;
    t = cyc;
  endtask

  task automatic drv1(input logic v, input logic s, input logic e,
                      input logic [7:0] d, output int t);
    @(negedge clk);
    b.din_valid = v; b.din_sop = s; b.din_eop = e; b.din = d;
    t = cyc;
  endtask

  task automatic idle(input int n);
    int t;
    for (int i = 0; i < n; i++) drv0(1'b0, 1'b0, 1'b0, 8'h00, t);
  endtask

  task automatic test_reset();
    sclr = 1'b1;
    a.din_valid = 0; a.din_sop = 0; a.din_eop = 0; a.din = 0;
    b.din_valid = 0; b.din_sop = 0; b.din_eop = 0; b.din = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (a.dout !== 2'b00 || a.dout_valid !== 1'b0 || a.frame_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_dut0 got dout=%b v=%b err=%b want 00 0 0", a.dout, a.dout_valid, a.frame_err);
    end
    checks++;
    if (b.dout !== 2'b00 || b.dout_valid !== 1'b0 || b.frame_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_dut1 got dout=%b v=%b err=%b want 00 0 0", b.dout, b.dout_valid, b.frame_err);
    end
    sclr = 1'b0;
    idle(2);
  endtask

  task automatic test_single();
    int t, n, ne;
    drv0(1, 1, 1, 8'h07, t);
    idle(6);
    checks++;
    if (hv0[t+3] !== 1'b1 || hd0[t+3] !== 2'b11) begin
      fails++;
      $display("FAIL single_word got v=%b dout=%b want 1 11", hv0[t+3], hd0[t+3]);
    end
    n = 0; ne = 0;
    for (int c = t + 1; c <= t + 5; c++) begin
      if (hv0[c] === 1'b1) n++;
      if (he0[c] === 1'b1) ne++;
    end
    checks++;
    if (n != 1 || ne != 0) begin
      fails++;
      $display("FAIL single_count got strobes=%0d errs=%0d want 1 0", n, ne);
    end
  endtask

  task automatic test_gap_frame();
    int t0, t, n, ne;
    drv0(1, 1, 0, 8'h01, t0);
    drv0(1, 0, 0, 8'h10, t);
    drv0(0, 0, 0, 8'h00, t);
    drv0(0, 0, 0, 8'h00, t);
    drv0(1, 0, 1, 8'h03, t);
    idle(6);
    checks++;
    if (hv0[t+3] !== 1'b1 || hd0[t+3] !== 2'b10) begin
      fails++;
      $display("FAIL gap_frame got v=%b dout=%b want 1 10", hv0[t+3], hd0[t+3]);
    end
    n = 0; ne = 0;
    for (int c = t0 + 1; c <= t + 5; c++) begin
      if (hv0[c] === 1'b1) n++;
      if (he0[c] === 1'b1) ne++;
    end
    checks++;
    if (n != 1 || ne != 0) begin
      fails++;
      $display("FAIL gap_count got strobes=%0d errs=%0d want 1 0", n, ne);
    end
  endtask

  task automatic test_back_to_back();
    int t, t2;
    drv0(1, 1, 1, 8'h07, t);
    drv0(1, 1, 1, 8'h01, t2);
    idle(6);
    checks++;
    if (hv0[t+3] !== 1'b1 || hd0[t+3] !== 2'b11 || he0[t+3] !== 1'b0) begin
      fails++;
      $display("FAIL b2b_first got v=%b dout=%b err=%b want 1 11 0", hv0[t+3], hd0[t+3], he0[t+3]);
    end
    checks++;
    if (hv0[t2+3] !== 1'b1 || hd0[t2+3] !== 2'b11 || he0[t2+3] !== 1'b0) begin
      fails++;
      $display("FAIL b2b_second got v=%b dout=%b err=%b want 1 11 0", hv0[t2+3], hd0[t2+3], he0[t2+3]);
    end
  endtask

  task automatic test_errors();
    int t, t1, t2, n;
    drv0(1, 0, 0, 8'h01, t);
    idle(5);
    n = 0;
    for (int c = t + 1; c <= t + 4; c++) if (hv0[c] === 1'b1) n++;
    checks++;
    if (he0[t+3] !== 1'b1 || n != 0) begin
      fails++;
      $display("FAIL orphan_word got err=%b strobes=%0d want 1 0", he0[t+3], n);
    end
    drv0(1, 1, 0, 8'h01, t1);
    drv0(1, 1, 1, 8'h02, t2);
    idle(5);
    checks++;
    if (he0[t1+3] !== 1'b0 || hv0[t1+3] !== 1'b0) begin
      fails++;
      $display("FAIL restart_first got err=%b v=%b want 0 0", he0[t1+3], hv0[t1+3]);
    end
    checks++;
    if (he0[t2+3] !== 1'b1 || hv0[t2+3] !== 1'b1 || hd0[t2+3] !== 2'b11) begin
      fails++;
      $display("FAIL restart_second got err=%b v=%b dout=%b want 1 1 11", he0[t2+3], hv0[t2+3], hd0[t2+3]);
    end
  endtask

  task automatic test_mid_reset();
    int t1, t, n;
    drv0(1, 1, 0, 8'h01, t1);
    @(negedge clk);
    sclr = 1'b1; a.din_valid = 0; a.din_sop = 0; a.din_eop = 0;
    drv0(1, 0, 0, 8'h10, t);
    sclr = 1'b0;
    drv0(1, 0, 1, 8'h03, t);
    idle(6);
    checks++;
    if (hd0[t1+2] !== 2'b00 || hv0[t1+2] !== 1'b0 || he0[t1+2] !== 1'b0) begin
      fails++;
      $display("FAIL midreset_clear got dout=%b v=%b err=%b want 00 0 0", hd0[t1+2], hv0[t1+2], he0[t1+2]);
    end
    n = 0;
    for (int c = t1 + 1; c <= t1 + 8; c++) if (hv0[c] === 1'b1) n++;
    checks++;
    if (n != 0) begin
      fails++;
      $display("FAIL midreset_strobes got %0d want 0", n);
    end
    checks++;
    if (he0[t+3] !== 1'b1 || hd0[t+3] !== 2'b00) begin
      fails++;
      $display("FAIL midreset_eop got err=%b dout=%b want 1 00", he0[t+3], hd0[t+3]);
    end
  endtask

  task automatic test_word_mode();
    int t, t2, ne;
    drv1(1, 0, 0, 8'h00, t);
    drv1(1, 0, 0, 8'h07, t2);
    drv1(0, 0, 0, 8'h00, ne);
    idle(4);
    checks++;
    if (hv1[t+1] !== 1'b1 || hd1[t+1] !== 2'b01) begin
      fails++;
      $display("FAIL word_zero got v=%b dout=%b want 1 01", hv1[t+1], hd1[t+1]);
    end
    checks++;
    if (hv1[t2+1] !== 1'b1 || hd1[t2+1] !== 2'b10 || hv1[t2+2] !== 1'b0) begin
      fails++;
      $display("FAIL word_07 got v=%b dout=%b next_v=%b want 1 10 0", hv1[t2+1], hd1[t2+1], hv1[t2+2]);
    end
    ne = 0;
    for (int c = t; c <= t2 + 3; c++) if (he1[c] === 1'b1) ne++;
    checks++;
    if (ne != 0) begin
      fails++;
      $display("FAIL word_err got %0d want 0", ne);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_gap_frame();
    test_back_to_back();
    test_errors();
    test_mid_reset();
    test_word_mode();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
